// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: command codes, owner FSM encoding and request decode for mem_bus_arbiter
package mem_arb_pkg;
   localparam logic [1:0] CMD_NONE   = 2'b00;
   localparam logic [1:0] CMD_MREAD  = 2'b01;
   localparam logic [1:0] CMD_MWRITE = 2'b10;
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } state_t;
   function automatic logic is_req(input logic [1:0] cmd);
      return cmd == CMD_MREAD || cmd == CMD_MWRITE;
   endfunction
endpackage

// File: rtl/mem_bus_arbiter_hold.sv
// arb_hold_counter: saturating count of granted owner cycles, terminal flag at MAX_HOLD-1
module arb_hold_counter #(
   parameter int MAX_HOLD = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);
   localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] TERM = CW'(MAX_HOLD - 1);
   logic [CW-1:0] r_cnt;
   // count up while enabled, holding at the terminal value; clear wins over count
   always_ff @(posedge clk)
      if (reset || i_clr) r_cnt <= '0;
      else if (i_en && !o_term) r_cnt <= r_cnt + 1'b1;
   assign o_term = r_cnt == TERM;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter for a single-port RAM with bounded hold and tagged read return; MEM_ARB_RR_EN selects round-robin IDLE ties (else m0 always wins ties)
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = 9,
   parameter int DW       = 16,
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    m0_cmd,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,
   input  logic [1:0]    m1_cmd,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   state_t r_state, w_next;
   logic w_req0, w_req1, w_term, w_tie_m1;
   logic r_rd_pend, r_rd_tag;
   assign w_req0 = is_req(m0_cmd);
   assign w_req1 = is_req(m1_cmd);
`ifdef MEM_ARB_RR_EN
   logic r_last_owner;
   // remember which master held the bus most recently so the next IDLE tie goes to the other one
   always_ff @(posedge clk)
      if (reset) r_last_owner <= 1'b1;
      else if (r_state == ST_OWN0) r_last_owner <= 1'b0;
      else if (r_state == ST_OWN1) r_last_owner <= 1'b1;
   assign w_tie_m1 = !r_last_owner;
`else
   assign w_tie_m1 = 1'b0;
`endif
   arb_hold_counter #(.MAX_HOLD(MAX_HOLD)) u_hold (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_next != r_state || r_state == ST_IDLE),
      .i_en   ((r_state == ST_OWN0 && w_req0) || (r_state == ST_OWN1 && w_req1)),
      .o_term (w_term)
   );
   // owner state register
   always_ff @(posedge clk)
      r_state <= reset ? ST_IDLE : w_next;
   // next owner: keep while requesting unless the hold limit is hit under contention
   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_OWN0: w_next = (w_req0 && !(w_req1 && w_term)) ? ST_OWN0 : w_req1 ? ST_OWN1 : ST_IDLE;
         ST_OWN1: w_next = (w_req1 && !(w_req0 && w_term)) ? ST_OWN1 : w_req0 ? ST_OWN0 : ST_IDLE;
         default: w_next = (w_req0 && w_req1) ? (w_tie_m1 ? ST_OWN1 : ST_OWN0) :
                           w_req0 ? ST_OWN0 : w_req1 ? ST_OWN1 : ST_IDLE;
      endcase
   end
   assign m0_gnt    = r_state == ST_OWN0;
   assign m1_gnt    = r_state == ST_OWN1;
   assign mem_cmd   = m0_gnt ? m0_cmd   : m1_gnt ? m1_cmd   : CMD_NONE;
   assign mem_addr  = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : '0;
   assign mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
   // tag each granted read with its master so the RAM's next-cycle data is routed back
   always_ff @(posedge clk)
      if (reset) begin
         r_rd_pend <= 1'b0;
         r_rd_tag  <= 1'b0;
      end else begin
         r_rd_pend <= (m0_gnt && m0_cmd == CMD_MREAD) || (m1_gnt && m1_cmd == CMD_MREAD);
         r_rd_tag  <= m1_gnt;
      end
   assign m0_rvalid = r_rd_pend && !r_rd_tag;
   assign m1_rvalid = r_rd_pend && r_rd_tag;
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grants, hold limit, tie rule and read return
module tb_mem_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  m0_cmd, m1_cmd, mem_cmd;
   logic [8:0]  m0_addr, m1_addr, mem_addr;
   logic [15:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata;
   logic [15:0] m0_rdata, m1_rdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [15:0] ram [0:511];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(9), .DW(16), .MAX_HOLD(8)) dut (
      .clk(clk), .reset(reset),
      .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
      .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // RAM model: contents reload to ram[a] = 0xA500 ^ a during reset, 1-cycle registered read
   always @(posedge clk) begin
      if (reset)
         for (int i = 0; i < 512; i++) ram[i] <= 16'hA500 ^ 16'(i);
      else if (mem_cmd == 2'b10)
         ram[mem_addr] <= mem_wdata;
      if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic idle_inputs;
      m0_cmd = 2'b00; m0_addr = '0; m0_wdata = '0;
      m1_cmd = 2'b00; m1_addr = '0; m1_wdata = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      m0_cmd = 2'b01; m0_addr = 9'h005;
      m1_cmd = 2'b01; m1_addr = 9'h006;
      tick();
      tick();
      settle();
      checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_m0_gnt got=%b want=0", m0_gnt); end
      checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_m1_gnt got=%b want=0", m1_gnt); end
      checks++; if (mem_cmd !== 2'b00) begin errors++; $display("FAIL reset_mem_cmd got=%b want=00", mem_cmd); end
      checks++; if (mem_addr !== 9'h000) begin errors++; $display("FAIL reset_mem_addr got=%h want=000", mem_addr); end
      checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b want=00", {m0_rvalid, m1_rvalid}); end
      idle_inputs();
      reset = 1'b0;
   endtask

   task automatic test_single_read;
      do_reset();
      m0_cmd = 2'b01; m0_addr = 9'h005;
      settle();
      checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL single_latency got=%b want=0", m0_gnt); end
      tick();
      settle();
      checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt got=%b want=1", m0_gnt); end
      checks++; if (mem_cmd !== 2'b01) begin errors++; $display("FAIL single_mem_cmd got=%b want=01", mem_cmd); end
      checks++; if (mem_addr !== 9'h005) begin errors++; $display("FAIL single_mem_addr got=%h want=005", mem_addr); end
      tick();
      m0_cmd = 2'b00;
      settle();
      checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got=%b want=1", m0_rvalid); end
      checks++; if (m0_rdata !== 16'hA505) begin errors++; $display("FAIL single_rdata got=%h want=a505", m0_rdata); end
      checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_rvalid got=%b want=0", m1_rvalid); end
      tick();
   endtask

   task automatic test_tie;
      logic exp_m1_first;
`ifdef MEM_ARB_RR_EN
      exp_m1_first = 1'b1;
`else
      exp_m1_first = 1'b0;
`endif
      do_reset();
      m0_cmd = 2'b01; m0_addr = 9'h020;
      m1_cmd = 2'b10; m1_addr = 9'h010; m1_wdata = 16'hBEEF;
      tick();
      settle();
      checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie1_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
      checks++; if (mem_cmd !== 2'b01) begin errors++; $display("FAIL tie1_mem_cmd got=%b want=01", mem_cmd); end
      tick();
      m0_cmd = 2'b00;
      settle();
      checks++; if (m0_rdata !== 16'hA520 || m0_rvalid !== 1'b1) begin errors++; $display("FAIL tie1_read got=%h/%b want=a520/1", m0_rdata, m0_rvalid); end
      tick();
      settle();
      checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL tie1_handover got=%b want=01", {m0_gnt, m1_gnt}); end
      checks++; if (mem_cmd !== 2'b10 || mem_addr !== 9'h010 || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL tie1_write got=%b/%h/%h want=10/010/beef", mem_cmd, mem_addr, mem_wdata); end
      tick();
      m1_cmd = 2'b00;
      tick();
      m0_cmd = 2'b01; m0_addr = 9'h010;
      tick();
      settle();
      checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL readback_gnt got=%b want=1", m0_gnt); end
      tick();
      m0_cmd = 2'b00;
      settle();
      checks++; if (m0_rdata !== 16'hBEEF || m0_rvalid !== 1'b1) begin errors++; $display("FAIL readback_data got=%h/%b want=beef/1", m0_rdata, m0_rvalid); end
      tick();
      m0_cmd = 2'b01; m0_addr = 9'h030;
      m1_cmd = 2'b01; m1_addr = 9'h031;
      tick();
      settle();
      checks++; if ({m0_gnt, m1_gnt} !== {!exp_m1_first, exp_m1_first}) begin errors++; $display("FAIL tie2_gnt got=%b want=%b", {m0_gnt, m1_gnt}, {!exp_m1_first, exp_m1_first}); end
      idle_inputs();
      tick();
   endtask

   task automatic test_hold_handover;
      logic        e0, e1, ev0, ev1;
      logic [15:0] ed;
      do_reset();
      m0_cmd = 2'b01; m0_addr = 9'h040;
      m1_cmd = 2'b01; m1_addr = 9'h041;
      for (int k = 1; k <= 10; k++) begin
         tick();
         settle();
         e0 = k <= 8;
         e1 = k >= 9;
         ev0 = k >= 2 && k <= 9;
         ev1 = k >= 10;
         ed = k <= 9 ? 16'hA540 : 16'hA541;
         checks++; if ({m0_gnt, m1_gnt} !== {e0, e1}) begin errors++; $display("FAIL hold_gnt cyc=%0d got=%b want=%b", k, {m0_gnt, m1_gnt}, {e0, e1}); end
         checks++; if ({m0_rvalid, m1_rvalid} !== {ev0, ev1}) begin errors++; $display("FAIL hold_rvalid cyc=%0d got=%b want=%b", k, {m0_rvalid, m1_rvalid}, {ev0, ev1}); end
         if (k >= 2) begin
            checks++; if (m0_rdata !== ed) begin errors++; $display("FAIL hold_rdata cyc=%0d got=%h want=%h", k, m0_rdata, ed); end
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_midread;
      do_reset();
      m0_cmd = 2'b01; m0_addr = 9'h060;
      tick();
      tick();
      reset = 1'b1;
      tick();
      settle();
      checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL midrst_rvalid got=%b want=00", {m0_rvalid, m1_rvalid}); end
      checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL midrst_gnt got=%b want=0", m0_gnt); end
      checks++; if (mem_cmd !== 2'b00) begin errors++; $display("FAIL midrst_mem_cmd got=%b want=00", mem_cmd); end
      reset = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_no_preempt;
      do_reset();
      m1_cmd = 2'b11; m1_addr = 9'h033;
      for (int k = 0; k < 3; k++) begin
         settle();
         checks++; if (m1_gnt !== 1'b0 || mem_cmd !== 2'b00) begin errors++; $display("FAIL cmd11 cyc=%0d got=%b/%b want=0/00", k, m1_gnt, mem_cmd); end
         tick();
      end
      m0_cmd = 2'b10; m0_addr = 9'h070; m0_wdata = 16'h1234;
      tick();
      for (int k = 1; k <= 20; k++) begin
         settle();
         checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL solo_gnt cyc=%0d got=%b want=10", k, {m0_gnt, m1_gnt}); end
         checks++; if (mem_cmd !== 2'b10 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL solo_mem cyc=%0d got=%b/%h want=10/1234", k, mem_cmd, mem_wdata); end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_single_read();
      test_tie();
      test_hold_handover();
      test_reset_midread();
      test_no_preempt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
